i2c_target_responder: RTL and testbench

- Synthesizable I2C target (slave) that sits on the same bus as the wishbone-controlled I2C master and answers its transfers.
- Decodes START, STOP and repeated START, matches a fixed 7-bit address, and ACKs write bytes.
- Delivers write bytes on a parallel strobe interface and sources read bytes through a request/valid handshake, stretching SCL until data is supplied.
- Used as the RTL bus partner in block-level and chip-level environments.

---
 rtl/i2c_target_responder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_responder.sv
// -----------------------------------------------------------------------------
// i2c_target_responder
//
// I2C target that answers a single fixed 7-bit address. Write bytes are
// ACKed and presented on a strobe interface; read bytes are fetched through a
// request/valid handshake while SCL is held low (clock stretching).
//
// Ports
//   clk_i       system clock
//   rst_i       synchronous reset, active low
//   scl_i/sda_i raw bus pin levels (synchronized internally)
//   scl_oe_o    1 = pull SCL low (stretch)
//   sda_oe_o    1 = pull SDA low (ACK / read data 0)
//   start_o     one-cycle pulse on START or repeated START
//   stop_o      one-cycle pulse on STOP
//   wr_data_o   last received write byte, held until the next one
//   wr_valid_o  one-cycle pulse, wr_data_o valid
//   rd_req_o    one-cycle pulse requesting the next read byte
//   rd_data_i   read byte, taken when rd_valid_i=1 while stretching
//   rd_valid_i  read byte valid
//   rd_nack_o   one-cycle pulse when the master NACKs a read byte
//   busy_o      1 from an address match until STOP or a non-matching address
// -----------------------------------------------------------------------------
module i2c_target_responder #(
  parameter logic [6:0] TARGET_ADDR    = 7'h22,
  parameter int         I2C_DATA_WIDTH = 8     // only 8 is supported
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_oe_o,
  output logic                      sda_oe_o,
  output logic                      start_o,
  output logic                      stop_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      wr_valid_o,
  output logic                      rd_req_o,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
  input  logic                      rd_valid_i,
  output logic                      rd_nack_o,
  output logic                      busy_o
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_WAIT,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'd7;

  // ---------------------------------------------------------------------------
  // Input synchronizers plus one history flop for edge detection.
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_hist;
  logic       sda_hist;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, giving a true shift chain.
    if (!rst_i) begin
      // Reset to the idle-bus level so leaving reset never looks like START.
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
    end
  end

  logic scl;
  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_cond;
  logic stop_cond;

  assign scl        = scl_sync[1];
  assign sda        = sda_sync[1];
  assign scl_rise   =  scl & ~scl_hist;
  assign scl_fall   = ~scl &  scl_hist;
  // SDA moving while SCL is high is a bus condition, never a data bit.
  assign start_cond =  scl &  sda_hist & ~sda;
  assign stop_cond  =  scl & ~sda_hist &  sda;

  // ---------------------------------------------------------------------------
  // Protocol FSM with registered outputs.
  // ---------------------------------------------------------------------------
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       rw;
  logic       ack_phase;   // ACK slot: SDA already driven / master ACK seen
  logic       rd_loaded;   // read byte captured, release stretch next cycle

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      rw         <= 1'b0;
      ack_phase  <= 1'b0;
      rd_loaded  <= 1'b0;
      scl_oe_o   <= 1'b0;
      sda_oe_o   <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      wr_data_o  <= '0;
      wr_valid_o <= 1'b0;
      rd_req_o   <= 1'b0;
      rd_nack_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      wr_valid_o <= 1'b0;
      rd_req_o   <= 1'b0;
      rd_nack_o  <= 1'b0;

      if (start_cond) begin
        // busy_o is kept across a repeated START; the next address decides.
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        ack_phase <= 1'b0;
        rd_loaded <= 1'b0;
        scl_oe_o  <= 1'b0;
        sda_oe_o  <= 1'b0;
        start_o   <= 1'b1;
      end else if (stop_cond) begin
        state     <= IDLE;
        ack_phase <= 1'b0;
        rd_loaded <= 1'b0;
        scl_oe_o  <= 1'b0;
        sda_oe_o  <= 1'b0;
        stop_o    <= 1'b1;
        busy_o    <= 1'b0;
      end else begin
        unique case (state)
          IDLE, WAIT_STOP: begin
          end

          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                // shift[6:0] holds the seven address bits; sda is R/W.
                if (shift[6:0] == TARGET_ADDR) begin
                  state  <= ADDR_ACK;
                  busy_o <= 1'b1;
                  rw     <= sda;
                end else begin
                  state  <= WAIT_STOP;
                  busy_o <= 1'b0;
                end
              end
            end
          end

          ADDR_ACK, WR_ACK: begin
            // First fall (8th) drives the ACK, second fall (9th) releases it.
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe_o  <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                sda_oe_o  <= 1'b0;
                ack_phase <= 1'b0;
                bit_cnt   <= 3'd0;
                if (state == WR_ACK || !rw) begin
                  state <= WR_DATA;
                end else begin
                  state     <= RD_WAIT;
                  rd_req_o  <= 1'b1;
                  scl_oe_o  <= 1'b1;
                  rd_loaded <= 1'b0;
                end
              end
            end
          end

          WR_DATA: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                wr_data_o  <= {shift[6:0], sda};
                wr_valid_o <= 1'b1;
                state      <= WR_ACK;
              end
            end
          end

          RD_WAIT: begin
            // SCL is held low here; bit7 goes out with the load, SCL is
            // released one cycle later so SDA is settled before the rise.
            if (!rd_loaded) begin
              if (rd_valid_i) begin
                shift     <= {rd_data_i[6:0], 1'b0};
                sda_oe_o  <= ~rd_data_i[7];
                rd_loaded <= 1'b1;
              end
            end else begin
              scl_oe_o  <= 1'b0;
              rd_loaded <= 1'b0;
              bit_cnt   <= 3'd0;
              state     <= RD_DATA;
            end
          end

          RD_DATA: begin
            // shift[7] is always the next bit to present on SDA.
            if (scl_fall) begin
              if (bit_cnt == LAST_BIT) begin
                sda_oe_o <= 1'b0;
                bit_cnt  <= 3'd0;
                state    <= RD_ACK;
              end else begin
                sda_oe_o <= ~shift[7];
                shift    <= {shift[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (sda) begin
                rd_nack_o <= 1'b1;
                state     <= WAIT_STOP;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              state     <= RD_WAIT;
              rd_req_o  <= 1'b1;
              scl_oe_o  <= 1'b1;
              rd_loaded <= 1'b0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_responder
//
// Drives the target with a simple clock-stretch-aware bus master model on an
// open-drain wired-AND bus, and answers read requests from a small table of
// (data, delay) responses.
// -----------------------------------------------------------------------------
module tb_i2c_target_responder;

  localparam int Q = 8;  // clk_i cycles per quarter SCL period

  logic       clk_i      = 1'b0;
  logic       rst_i      = 1'b0;
  logic       scl_m      = 1'b1;
  logic       sda_m      = 1'b1;
  logic       rd_valid_i = 1'b0;
  logic [7:0] rd_data_i  = 8'h00;

  logic       scl_i;
  logic       sda_i;
  logic       scl_oe_o;
  logic       sda_oe_o;
  logic       start_o;
  logic       stop_o;
  logic [7:0] wr_data_o;
  logic       wr_valid_o;
  logic       rd_req_o;
  logic       rd_nack_o;
  logic       busy_o;

  assign scl_i = scl_m & ~scl_oe_o;
  assign sda_i = sda_m & ~sda_oe_o;

  always #5 clk_i = ~clk_i;

  i2c_target_responder #(
    .TARGET_ADDR   (7'h22),
    .I2C_DATA_WIDTH(8)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_oe_o  (scl_oe_o),
    .sda_oe_o  (sda_oe_o),
    .start_o   (start_o),
    .stop_o    (stop_o),
    .wr_data_o (wr_data_o),
    .wr_valid_o(wr_valid_o),
    .rd_req_o  (rd_req_o),
    .rd_data_i (rd_data_i),
    .rd_valid_i(rd_valid_i),
    .rd_nack_o (rd_nack_o),
    .busy_o    (busy_o)
  );

  // ---------------------------------------------------------------------------
  // Event monitor (samples on the falling edge).
  // ---------------------------------------------------------------------------
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_start = 0, n_stop = 0, n_wr = 0, n_req = 0, n_nack = 0;
  int         n_sda_oe = 0;
  int         cur_stretch = 0, n_stretch = 0;
  int         stretch_log[16];
  logic [7:0] wr_log[32];

  always @(negedge clk_i) begin
    if (start_o)   n_start++;
    if (stop_o)    n_stop++;
    if (rd_req_o)  n_req++;
    if (rd_nack_o) n_nack++;
    if (sda_oe_o)  n_sda_oe++;
    if (wr_valid_o && n_wr < 32) begin
      wr_log[n_wr] = wr_data_o;
      n_wr++;
    end
    if (scl_oe_o) begin
      cur_stretch++;
    end else if (cur_stretch != 0) begin
      if (n_stretch < 16) stretch_log[n_stretch] = cur_stretch;
      n_stretch++;
      cur_stretch = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data responder: byte k is supplied rsp_delay[k] cycles after its
  // rd_req_o (0 = in the request cycle itself).
  // ---------------------------------------------------------------------------
  logic [7:0] rsp_data[4]  = '{8'h96, 8'h0F, 8'h5A, 8'hC3};
  int         rsp_delay[4] = '{20, 0, 3, 200};
  int         rsp_idx = 0;
  int         rsp_cnt = -1;

  always @(negedge clk_i) begin
    rd_valid_i = 1'b0;
    if (rd_req_o && rsp_idx < 4) rsp_cnt = rsp_delay[rsp_idx];
    if (rsp_cnt == 0) begin
      rd_valid_i = 1'b1;
      rd_data_i  = rsp_data[rsp_idx];
      rsp_idx++;
      rsp_cnt = -1;
    end else if (rsp_cnt > 0) begin
      rsp_cnt--;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (scl_i !== 1'b1 && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check("scl_release", {31'd0, scl_i}, 32'd1);
  endtask

  task automatic m_bit(input logic b, output logic s);
    sda_m = b;
    wait_cyc(Q);
    scl_m = 1'b1;
    wait_scl_high();
    wait_cyc(Q);
    s = sda_i;
    wait_cyc(Q);
    scl_m = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic m_start();
    sda_m = 1'b1;
    wait_cyc(Q);
    scl_m = 1'b1;
    wait_scl_high();
    wait_cyc(Q);
    sda_m = 1'b0;
    wait_cyc(Q);
    scl_m = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic m_stop();
    sda_m = 1'b0;
    wait_cyc(Q);
    scl_m = 1'b1;
    wait_scl_high();
    wait_cyc(Q);
    sda_m = 1'b1;
    wait_cyc(Q);
  endtask

  // Sends one byte, returns the level seen on the 9th clock (0 = ACK).
  task automatic m_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    m_bit(1'b1, ack);
  endtask

  // Reads one byte, then answers with nack (0 = ACK, 1 = NACK).
  task automatic m_read(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    m_bit(nack, s);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data;
    logic       match;
  } wr_vec_t;

  wr_vec_t vecs[6];

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d0;
    logic [7:0] d1;
    int         b_start, b_stop, b_wr, b_req, b_nack, b_oe, b_str;

    vecs[0] = '{8'h44, 8'h5A, 1'b1};
    vecs[1] = '{8'h46, 8'hFF, 1'b0};  // 0x23 write
    vecs[2] = '{8'h44, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h81, 1'b0};  // general call, not answered
    vecs[4] = '{8'hC4, 8'h44, 1'b0};  // 0x62: differs only in the MSB
    vecs[5] = '{8'h44, 8'hFF, 1'b1};

    // ---- reset state ----
    rst_i = 1'b0;
    wait_cyc(4);
    check("rst_oe", {30'd0, scl_oe_o, sda_oe_o}, 32'd0);
    check("rst_pulses", {27'd0, start_o, stop_o, wr_valid_o, rd_req_o, rd_nack_o}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b1;
    wait_cyc(10);
    check("idle_busy", {31'd0, busy_o}, 32'd0);

    // ---- two-byte write to 0x22 ----
    b_start = n_start; b_stop = n_stop; b_wr = n_wr;
    m_start();
    m_byte(8'h44, ack);
    check("w2_addr_ack", {31'd0, ack}, 32'd0);
    check("w2_busy_mid", {31'd0, busy_o}, 32'd1);
    m_byte(8'hA5, ack);
    check("w2_d0_ack", {31'd0, ack}, 32'd0);
    m_byte(8'h3C, ack);
    check("w2_d1_ack", {31'd0, ack}, 32'd0);
    m_stop();
    wait_cyc(10);
    check("w2_wr_cnt", n_wr - b_wr, 32'd2);
    check("w2_byte0", {24'd0, wr_log[b_wr]}, 32'hA5);
    check("w2_byte1", {24'd0, wr_log[b_wr+1]}, 32'h3C);
    check("w2_start_cnt", n_start - b_start, 32'd1);
    check("w2_stop_cnt", n_stop - b_stop, 32'd1);
    check("w2_busy_end", {31'd0, busy_o}, 32'd0);

    // ---- table-driven single-byte writes ----
    for (int v = 0; v < 6; v++) begin
      b_wr = n_wr; b_oe = n_sda_oe; b_start = n_start; b_stop = n_stop;
      m_start();
      m_byte(vecs[v].addr_byte, ack);
      check($sformatf("v%0d_addr_ack", v), {31'd0, ack}, {31'd0, ~vecs[v].match});
      check($sformatf("v%0d_busy_mid", v), {31'd0, busy_o}, {31'd0, vecs[v].match});
      m_byte(vecs[v].data, ack);
      check($sformatf("v%0d_data_ack", v), {31'd0, ack}, {31'd0, ~vecs[v].match});
      m_stop();
      wait_cyc(10);
      check($sformatf("v%0d_wr_cnt", v), n_wr - b_wr, vecs[v].match ? 32'd1 : 32'd0);
      if (vecs[v].match)
        check($sformatf("v%0d_wr_data", v), {24'd0, wr_log[b_wr]}, {24'd0, vecs[v].data});
      else
        check($sformatf("v%0d_no_sda_drive", v), n_sda_oe - b_oe, 32'd0);
      check($sformatf("v%0d_start_stop", v), (n_start - b_start) * 16 + (n_stop - b_stop), 32'h11);
      check($sformatf("v%0d_busy_end", v), {31'd0, busy_o}, 32'd0);
    end

    // ---- read: delayed first byte, ACK, then NACK ----
    b_req = n_req; b_nack = n_nack; b_str = n_stretch;
    m_start();
    m_byte(8'h45, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd0);
    m_read(1'b0, d0);
    m_read(1'b1, d1);
    check("rd_nack_pulse", n_nack - b_nack, 32'd1);
    check("rd_busy_before_stop", {31'd0, busy_o}, 32'd1);
    m_stop();
    wait_cyc(60);
    check("rd_byte0", {24'd0, d0}, 32'h96);
    check("rd_byte1", {24'd0, d1}, 32'h0F);
    check("rd_req_cnt", n_req - b_req, 32'd2);
    check("rd_stretch_cnt", n_stretch - b_str, 32'd2);
    check("rd_stretch0_len", stretch_log[b_str], 32'd22);
    check("rd_stretch1_len", stretch_log[b_str+1], 32'd2);
    check("rd_busy_end", {31'd0, busy_o}, 32'd0);

    // ---- write, repeated START, read ----
    b_start = n_start; b_stop = n_stop; b_wr = n_wr; b_req = n_req;
    m_start();
    m_byte(8'h44, ack);
    check("rs_waddr_ack", {31'd0, ack}, 32'd0);
    m_byte(8'h11, ack);
    check("rs_wdata_ack", {31'd0, ack}, 32'd0);
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(d0[0] | 1'b1 ? (8'h45 >> i) & 8'h01 ? 1'b1 : 1'b0 : 1'b0, s);
    check("rs_no_early_req", n_req - b_req, 32'd0);
    m_bit(1'b1, ack);
    check("rs_raddr_ack", {31'd0, ack}, 32'd0);
    m_read(1'b1, d0);
    m_stop();
    wait_cyc(10);
    check("rs_start_cnt", n_start - b_start, 32'd2);
    check("rs_stop_cnt", n_stop - b_stop, 32'd1);
    check("rs_wr_data", {24'd0, wr_log[b_wr]}, 32'h11);
    check("rs_rd_byte", {24'd0, d0}, 32'h5A);
    check("rs_req_cnt", n_req - b_req, 32'd1);

    // ---- reset during the RD_WAIT stretch ----
    m_start();
    m_byte(8'h45, ack);
    check("rr_addr_ack", {31'd0, ack}, 32'd0);
    wait_cyc(10);
    check("rr_stretching", {31'd0, scl_oe_o}, 32'd1);
    rst_i = 1'b0;
    wait_cyc(1);
    check("rr_oe_released", {30'd0, scl_oe_o, sda_oe_o}, 32'd0);
    check("rr_pulses", {27'd0, start_o, stop_o, wr_valid_o, rd_req_o, rd_nack_o}, 32'd0);
    check("rr_wr_data", {24'd0, wr_data_o}, 32'd0);
    check("rr_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b1;
    m_stop();
    b_wr = n_wr;
    m_start();
    m_byte(8'h44, ack);
    check("rr_w_addr_ack", {31'd0, ack}, 32'd0);
    m_byte(8'hE7, ack);
    check("rr_w_data_ack", {31'd0, ack}, 32'd0);
    m_stop();
    wait_cyc(10);
    check("rr_w_wr_cnt", n_wr - b_wr, 32'd1);
    check("rr_w_wr_data", {24'd0, wr_log[b_wr]}, 32'hE7);

    // ---- START after 4 address bits restarts the address ----
    b_start = n_start; b_wr = n_wr;
    m_start();
    m_bit(1'b0, s);
    m_bit(1'b1, s);
    m_bit(1'b0, s);
    m_bit(1'b0, s);
    m_start();
    m_byte(8'h44, ack);
    check("ab_addr_ack", {31'd0, ack}, 32'd0);
    m_byte(8'h77, ack);
    check("ab_data_ack", {31'd0, ack}, 32'd0);
    m_stop();
    wait_cyc(10);
    check("ab_start_cnt", n_start - b_start, 32'd2);
    check("ab_wr_cnt", n_wr - b_wr, 32'd1);
    check("ab_wr_data", {24'd0, wr_log[b_wr]}, 32'h77);
    check("ab_busy_end", {31'd0, busy_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
